// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU op codes, operand selects
// and forwarding-source encoding.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_AUIPC = 4'b1110;
    localparam logic [3:0] ALU_LUI   = 4'b1111;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_src_e;

    // A later stage supplies a source only if it writes a nonzero matching index.
    function automatic logic src_hit(input logic wren, input logic [4:0] rd,
                                     input logic [4:0] rs);
        return wren && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats
// the value captured from the register file.
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [4:0]      src_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            mem_wren,
    input  logic [4:0]      mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_wren,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    fwd_src_e src;

    always_comb begin
        src = FWD_REG;
        if (FWD_EN && src_hit(mem_wren, mem_addr, src_addr)) begin
            src = FWD_MEM;
        end else if (FWD_EN && src_hit(wb_wren, wb_addr, src_addr)) begin
            src = FWD_WB;
        end
    end

    always_comb begin
        unique case (src)
            FWD_MEM: fwd_data = mem_data;
            FWD_WB:  fwd_data = wb_data;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB write-through on
// capture and EX-side operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_id_valid,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [4:0]      i_id_rs1_addr,
    input  logic [4:0]      i_id_rs2_addr,
    input  logic [4:0]      i_id_rd_addr,
    input  logic [3:0]      i_id_alu_op,
    input  logic            i_id_opa_sel,
    input  logic            i_id_opb_sel,
    input  logic            i_id_rd_wren,
    input  logic            i_id_mem_rden,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [4:0]      i_mem_rd_addr,
    input  logic            i_mem_rd_wren,
    input  logic [XLEN-1:0] i_mem_alu_data,
    input  logic [4:0]      i_wb_rd_addr,
    input  logic            i_wb_rd_wren,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_operand_a,
    output logic [XLEN-1:0] o_operand_b,
    output logic [3:0]      o_alu_op,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [4:0]      o_ex_rd_addr,
    output logic            o_ex_rd_wren,
    output logic            o_ex_mem_rden,
    output logic [XLEN-1:0] o_ex_store_data,
    output logic            o_load_use
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [3:0]      alu_op;
        logic            opa_sel;
        logic            opb_sel;
        logic            rd_wren;
        logic            mem_rden;
    } ex_reg_t;

    ex_reg_t         ex_d, ex_q;
    logic            is_store, rs1_used, rs2_used, load_use;
    logic            bubble, load_en;
    logic [XLEN-1:0] rs1_cap, rs2_cap, rs1_fwd, rs2_fwd;

    // Stores read rs2 as data even though operand b selects the immediate.
    assign is_store = !i_id_rd_wren && (i_id_alu_op == ALU_ADD);
    assign rs1_used = (i_id_opa_sel == OPA_RS1);
    assign rs2_used = (i_id_opb_sel == OPB_RS2) || is_store;
    assign load_use = ex_q.valid && ex_q.mem_rden && (ex_q.rd_addr != 5'd0) && i_id_valid &&
                      ((rs1_used && (ex_q.rd_addr == i_id_rs1_addr)) ||
                       (rs2_used && (ex_q.rd_addr == i_id_rs2_addr)));

    assign rs1_cap = (FWD_EN && src_hit(i_wb_rd_wren, i_wb_rd_addr, i_id_rs1_addr)) ?
                     i_wb_data : i_id_rs1_data;
    assign rs2_cap = (FWD_EN && src_hit(i_wb_rd_wren, i_wb_rd_addr, i_id_rs2_addr)) ?
                     i_wb_data : i_id_rs2_data;

    // Flush overrides stall; load-use and empty ID only bubble when not stalled.
    assign load_en = i_flush || !i_stall;
    assign bubble  = i_flush || load_use || !i_id_valid;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = i_id_pc;
            ex_d.rs1_data = rs1_cap;
            ex_d.rs2_data = rs2_cap;
            ex_d.imm      = i_id_imm;
            ex_d.rs1_addr = i_id_rs1_addr;
            ex_d.rs2_addr = i_id_rs2_addr;
            ex_d.rd_addr  = i_id_rd_addr;
            ex_d.alu_op   = i_id_alu_op;
            ex_d.opa_sel  = i_id_opa_sel;
            ex_d.opb_sel  = i_id_opb_sel;
            ex_d.rd_wren  = i_id_rd_wren;
            ex_d.mem_rden = i_id_mem_rden;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q <= '0;
        end else if (load_en) begin
            ex_q <= ex_d;
        end
    end

    fwd_unit #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs1 (
        .src_addr (ex_q.rs1_addr),
        .reg_data (ex_q.rs1_data),
        .mem_wren (i_mem_rd_wren),
        .mem_addr (i_mem_rd_addr),
        .mem_data (i_mem_alu_data),
        .wb_wren  (i_wb_rd_wren),
        .wb_addr  (i_wb_rd_addr),
        .wb_data  (i_wb_data),
        .fwd_data (rs1_fwd)
    );

    fwd_unit #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs2 (
        .src_addr (ex_q.rs2_addr),
        .reg_data (ex_q.rs2_data),
        .mem_wren (i_mem_rd_wren),
        .mem_addr (i_mem_rd_addr),
        .mem_data (i_mem_alu_data),
        .wb_wren  (i_wb_rd_wren),
        .wb_addr  (i_wb_rd_addr),
        .wb_data  (i_wb_data),
        .fwd_data (rs2_fwd)
    );

    assign o_operand_a     = (ex_q.opa_sel == OPA_PC) ? ex_q.pc : rs1_fwd;
    assign o_operand_b     = (ex_q.opb_sel == OPB_IMM) ? ex_q.imm : rs2_fwd;
    assign o_ex_store_data = rs2_fwd;
    assign o_alu_op        = ex_q.alu_op;
    assign o_ex_valid      = ex_q.valid;
    assign o_ex_pc         = ex_q.pc;
    assign o_ex_rd_addr    = ex_q.rd_addr;
    assign o_ex_rd_wren    = ex_q.valid && ex_q.rd_wren;
    assign o_ex_mem_rden   = ex_q.valid && ex_q.mem_rden;
    assign o_load_use      = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 0, opa_sel = 0, opb_sel = 0, rd_wren = 0, mem_rden = 0;
    logic [31:0] id_pc = 0, rs1_data = 0, rs2_data = 0, imm = 0;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
    logic [3:0]  alu_op = 0;
    logic        stall = 0, flush = 0;
    logic [4:0]  mem_addr = 0, wb_addr = 0;
    logic        mem_wren = 0, wb_wren = 0;
    logic [31:0] mem_data = 0, wb_data = 0;

    logic [31:0] op_a, op_b, ex_pc, store_data;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_wr, ex_ld, load_use;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_id_valid      (id_valid),
        .i_id_pc         (id_pc),
        .i_id_rs1_data   (rs1_data),
        .i_id_rs2_data   (rs2_data),
        .i_id_imm        (imm),
        .i_id_rs1_addr   (rs1_addr),
        .i_id_rs2_addr   (rs2_addr),
        .i_id_rd_addr    (rd_addr),
        .i_id_alu_op     (alu_op),
        .i_id_opa_sel    (opa_sel),
        .i_id_opb_sel    (opb_sel),
        .i_id_rd_wren    (rd_wren),
        .i_id_mem_rden   (mem_rden),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_mem_rd_addr   (mem_addr),
        .i_mem_rd_wren   (mem_wren),
        .i_mem_alu_data  (mem_data),
        .i_wb_rd_addr    (wb_addr),
        .i_wb_rd_wren    (wb_wren),
        .i_wb_data       (wb_data),
        .o_operand_a     (op_a),
        .o_operand_b     (op_b),
        .o_alu_op        (ex_op),
        .o_ex_valid      (ex_valid),
        .o_ex_pc         (ex_pc),
        .o_ex_rd_addr    (ex_rd),
        .o_ex_rd_wren    (ex_wr),
        .o_ex_mem_rden   (ex_ld),
        .o_ex_store_data (store_data),
        .o_load_use      (load_use)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the instruction currently sitting in EX (all zero = empty slot).
    logic        m_v, m_asel, m_bsel, m_wr, m_ld;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;

    task automatic model_clear();
        m_v = 0; m_asel = 0; m_bsel = 0; m_wr = 0; m_ld = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 0) return v;
        if (mem_wren && mem_addr == a) return mem_data;
        if (wb_wren && wb_addr == a) return wb_data;
        return v;
    endfunction

    function automatic logic exp_load_use();
        logic reads1, reads2;
        reads1 = !opa_sel && rs1_addr == m_rd;
        reads2 = (!opb_sel || (!rd_wren && alu_op == 4'd0)) && rs2_addr == m_rd;
        return m_v && m_ld && m_rd != 0 && id_valid && (reads1 || reads2);
    endfunction

    initial model_clear();
    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            model_clear();
        end else if (stall) begin
            // slot keeps its instruction
        end else if (exp_load_use() || !id_valid) begin
            model_clear();
        end else begin
            m_v = 1; m_pc = id_pc; m_imm = imm; m_op = alu_op;
            m_rs1 = rs1_addr; m_rs2 = rs2_addr; m_rd = rd_addr;
            m_asel = opa_sel; m_bsel = opb_sel; m_wr = rd_wren; m_ld = mem_rden;
            m_a = (wb_wren && wb_addr != 0 && wb_addr == rs1_addr) ? wb_data : rs1_data;
            m_b = (wb_wren && wb_addr != 0 && wb_addr == rs2_addr) ? wb_data : rs2_data;
        end
    end

    // Compare process: late in the low phase, after all stimulus for the cycle.
    always @(negedge clk) begin
        #4;
        chk("m_operand_a", op_a, m_asel ? m_pc : fwd(m_rs1, m_a));
        chk("m_operand_b", op_b, m_bsel ? m_imm : fwd(m_rs2, m_b));
        chk("m_store_data", store_data, fwd(m_rs2, m_b));
        chk("m_alu_op", {28'd0, ex_op}, {28'd0, m_op});
        chk("m_valid", {31'd0, ex_valid}, {31'd0, m_v});
        chk("m_pc", ex_pc, m_pc);
        chk("m_rd", {27'd0, ex_rd}, {27'd0, m_rd});
        chk("m_rd_wren", {31'd0, ex_wr}, {31'd0, m_v & m_wr});
        chk("m_mem_rden", {31'd0, ex_ld}, {31'd0, m_v & m_ld});
        chk("m_load_use", {31'd0, load_use}, {31'd0, exp_load_use()});
    end

    task automatic id_none();
        id_valid = 0; id_pc = 0; rs1_data = 0; rs2_data = 0; imm = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0; alu_op = 0;
        opa_sel = 0; opb_sel = 0; rd_wren = 0; mem_rden = 0;
        stall = 0; flush = 0; mem_wren = 0; wb_wren = 0;
        mem_addr = 0; wb_addr = 0; mem_data = 0; wb_data = 0;
    endtask

    task automatic id_alu(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [3:0] op);
        id_valid = 1; id_pc = pc; rs1_addr = r1; rs1_data = d1; rs2_addr = r2;
        rs2_data = d2; rd_addr = rd; alu_op = op; opa_sel = 0; opb_sel = 0;
        rd_wren = 1; mem_rden = 0; imm = 32'h0000_0abc;
    endtask

    initial begin
        id_none();
        #3;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_operand_a", op_a, 32'd0);
        chk("rst_load_use", {31'd0, load_use}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // ADD x3 = x1 + x2, rs1 = 5, rs2 = 7
        id_alu(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'b0000);
        @(posedge clk); #1;
        chk("add_operand_a", op_a, 32'd5);
        chk("add_operand_b", op_b, 32'd7);
        chk("add_alu_op", {28'd0, ex_op}, 32'd0);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);

        // Forwarding priority on EX rs1 = x1
        @(negedge clk);
        id_none();
        mem_wren = 1; mem_addr = 5'd1; mem_data = 32'h10;
        wb_wren = 1; wb_addr = 5'd1; wb_data = 32'h20;
        #1 chk("fwd_mem_wins", op_a, 32'h10);
        mem_wren = 0;
        #1 chk("fwd_wb", op_a, 32'h20);
        wb_wren = 0;
        #1 chk("fwd_none", op_a, 32'd5);
        @(negedge clk);
        id_alu(32'h104, 5'd0, 32'h55, 5'd2, 32'd7, 5'd3, 4'b0000);
        @(negedge clk);
        id_none();
        mem_wren = 1; mem_addr = 5'd0; mem_data = 32'h10;
        wb_wren = 1; wb_addr = 5'd0; wb_data = 32'h20;
        #1 chk("fwd_x0", op_a, 32'h55);

        // Load-use: LW x4 in EX
        @(negedge clk);
        id_none();
        id_valid = 1; rs1_addr = 5'd1; rd_addr = 5'd4; rd_wren = 1; mem_rden = 1;
        opb_sel = 1; imm = 32'h8;
        @(negedge clk);
        id_alu(32'h108, 5'd2, 32'd1, 5'd4, 32'd2, 5'd5, 4'b0000);
        #1 chk("lu_rs2", {31'd0, load_use}, 32'd1);
        rs2_addr = 5'd0;
        #1 chk("lu_rs2_x0", {31'd0, load_use}, 32'd0);
        rs2_addr = 5'd4; opb_sel = 1;
        #1 chk("lu_imm_noload", {31'd0, load_use}, 32'd0);
        rd_wren = 0;
        #1 chk("lu_store", {31'd0, load_use}, 32'd1);
        @(posedge clk); #1;
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);

        // Flush with stall, then stall alone for three cycles
        @(negedge clk);
        id_alu(32'h10c, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 4'b0000);
        @(negedge clk);
        flush = 1; stall = 1;
        @(posedge clk); #1;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_rd_wren", {31'd0, ex_wr}, 32'd0);
        @(negedge clk);
        flush = 0; stall = 0;
        id_alu(32'h200, 5'd6, 32'h11, 5'd7, 32'h22, 5'd6, 4'b0001);
        @(negedge clk);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_alu(32'h300 + i, 5'd8, 32'h99, 5'd9, 32'h98, 5'd10, 4'b0110);
            @(posedge clk); #1;
            chk("stall_operand_a", op_a, 32'h11);
            chk("stall_operand_b", op_b, 32'h22);
            chk("stall_pc", ex_pc, 32'h200);
            chk("stall_alu_op", {28'd0, ex_op}, 32'd1);
            chk("stall_rd", {27'd0, ex_rd}, 32'd6);
            @(negedge clk);
        end

        // WB write-through at capture
        id_none();
        wb_wren = 1; wb_addr = 5'd5; wb_data = 32'hABCD;
        id_alu(32'h400, 5'd5, 32'd0, 5'd0, 32'd0, 5'd6, 4'b0000);
        @(posedge clk); #1;
        wb_wren = 0;
        #1 chk("wb_capture", op_a, 32'hABCD);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        id_none();
        id_alu(32'h500, 5'd1, 32'h77, 5'd2, 32'h66, 5'd3, 4'b0100);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_operand_a", op_a, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_alu_op", {28'd0, ex_op}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            id_valid = ($urandom_range(3) != 0);
            id_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            rs1_addr = 5'($urandom_range(7)); rs2_addr = 5'($urandom_range(7));
            rd_addr = 5'($urandom_range(7));
            alu_op = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom);
            opa_sel = 1'($urandom); opb_sel = 1'($urandom);
            rd_wren = 1'($urandom); mem_rden = ($urandom_range(9) < 4);
            stall = ($urandom_range(9) < 2); flush = ($urandom_range(9) == 0);
            mem_wren = 1'($urandom); mem_addr = 5'($urandom_range(7)); mem_data = $urandom;
            wb_wren = 1'($urandom); wb_addr = 5'($urandom_range(7)); wb_data = $urandom;
            if ($urandom_range(199) == 0) begin
                #3 rst_n = 0;
                #1 rst_n = 1;
            end
        end

        @(negedge clk);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width.
REQ-002 Parameter FWD_EN, 1, 1 = forwarding enabled; 0 = operands always come from the captured register-file data.
REQ-003 The block SHALL have one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-004 Ports SHALL be exactly:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_id_valid  in  1  ID instruction valid
- i_id_pc  in  XLEN  ID PC
- i_id_rs1_data, i_id_rs2_data  in  XLEN  register-file read data
- i_id_imm  in  XLEN  decoded immediate
- i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  in  5  register indices
- i_id_alu_op  in  4  ALU op code
- i_id_opa_sel  in  1  0 = rs1, 1 = PC
- i_id_opb_sel  in  1  0 = rs2, 1 = imm
- i_id_rd_wren  in  1  writes rd
- i_id_mem_rden  in  1  is a load
- i_stall  in  1  freeze EX register
- i_flush  in  1  branch mispredict, kill EX
- i_mem_rd_addr  in  5  EX/MEM destination
- i_mem_rd_wren  in  1  EX/MEM writes rd
- i_mem_alu_data  in  XLEN  EX/MEM result
- i_wb_rd_addr  in  5  MEM/WB destination
- i_wb_rd_wren  in  1  MEM/WB writes rd
- i_wb_data  in  XLEN  MEM/WB result
- o_operand_a, o_operand_b  out  XLEN  ALU operands
- o_alu_op  out  4  ALU op code
- o_ex_valid  out  1  EX slot valid
- o_ex_pc  out  XLEN  EX PC
- o_ex_rd_addr  out  5  EX destination
- o_ex_rd_wren, o_ex_mem_rden  out  1  EX control, gated by valid
- o_ex_store_data  out  XLEN  forwarded rs2 value
- o_load_use  out  1  load-use hazard, upstream holds IF/ID

Function
REQ-005 The EX register SHALL update on the rising i_clk edge with priority: flush > stall > load-use bubble > capture.
REQ-006 On flush, the register SHALL load a bubble: valid, rd_wren, mem_rden = 0; alu_op = 4'b0000; all data fields = 0.
REQ-007 On stall without flush, all EX register fields SHALL hold their values.
REQ-008 o_load_use SHALL be combinational: o_ex_valid & o_ex_mem_rden & (o_ex_rd_addr != 0) & i_id_valid & (o_ex_rd_addr matches i_id_rs1_addr or i_id_rs2_addr).
- The match on rs1 counts only when i_id_opa_sel = 0.
- The match on rs2 counts for opb_sel = 0 or for a store.
- A store is identified as rd_wren = 0 and alu_op = ADD.
REQ-009 When o_load_use is high, with no flush and no stall, the register SHALL load a bubble.
REQ-010 On capture, rs1/rs2 data SHALL bypass the register file with i_wb_data when i_wb_rd_wren is set, the index is nonzero and i_wb_rd_addr equals the source index.
REQ-011 Forwarding SHALL be combinational on the registered sources, in this priority:
- EX/MEM (i_mem_rd_wren, i_mem_rd_addr match, nonzero): i_mem_alu_data.
- else MEM/WB (i_wb_rd_wren, match, nonzero): i_wb_data.
- else the captured data.
REQ-012 Register x0 SHALL never be forwarded.
REQ-013 o_operand_a SHALL be the registered PC when opa_sel = 1, otherwise forwarded rs1.
REQ-014 o_operand_b SHALL be the registered imm when opb_sel = 1, otherwise forwarded rs2.
REQ-015 o_ex_store_data SHALL always be forwarded rs2.
REQ-016 Latency SHALL be one cycle from ID inputs to EX outputs; forwarding adds zero cycles.
REQ-017 When i_id_valid = 0 on capture, a bubble SHALL be loaded.

Reset
REQ-018 While i_rst_n is low, all registered fields SHALL be 0, immediately and asynchronously.
- o_ex_valid = 0, o_alu_op = 4'b0000.
- Operands and PC = 0.
- o_load_use = 0.
REQ-019 Release of i_rst_n SHALL take effect on the next rising edge with no extra latency; reset mid-stall SHALL discard the held instruction.

Structure
REQ-020 The shared package SHALL hold the ALU op-code constants:
- ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110.
- SLL 0111, SRL 1000, SRA 1001, AUIPC 1110, LUI 1111.
REQ-021 The shared package SHALL also hold the operand-select constants and the forwarding-source enum (REG, MEM, WB).
REQ-022 The forwarding priority logic SHALL be one sub-module, fwd_unit, instantiated once per source operand.

Verification
REQ-023 ADD x3 = x1 + x2 is captured with rs1 = 5, rs2 = 7, and no hazards -> next cycle operand_a = 5, operand_b = 7, alu_op = 0000, valid = 1.
REQ-024 EX/MEM writes x1 = 0x10 and MEM/WB writes x1 = 0x20; EX rs1 = x1 -> operand_a = 0x10. Remove the EX/MEM match -> 0x20. With rd = x0 -> the register value.
REQ-025 EX holds LW x4; ID reads x4 as rs2 -> o_load_use = 1 and next cycle valid = 0. With rs2 = x0 -> o_load_use = 0.
REQ-026 Flush and stall asserted together with a valid ID -> next cycle valid = 0, rd_wren = 0. Stall alone -> all outputs unchanged for 3 cycles.
REQ-027 Capture with WB writing x5 = 0xABCD and ID reading x5 with stale data 0 -> the captured operand = 0xABCD.
REQ-028 i_rst_n is dropped asynchronously mid-cycle with valid = 1 -> all outputs are 0 before the next edge.
